// File: rtl/ks_pkg.sv
// Shared definitions for the Karplus-Strong string voice and its excitation sequencer.
package ks_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_PLUCK  = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;

   localparam logic [15:0] LFSR_POLY      = 16'hB400;
   localparam int          DEFAULT_PERIOD = 32;

   // A zero period would stall the string and anything past the wavetable depth cannot be played.
   function automatic logic [31:0] clamp_period(input logic [31:0] period,
                                                input logic [31:0] max_len);
      if (period == 32'd0) return 32'd1;
      if (period > max_len) return max_len;
      return period;
   endfunction

endpackage

// File: rtl/ks_lfsr.sv
// Free-running 16-bit Galois LFSR (right shift) supplying excitation noise to the string.
module ks_lfsr
   import ks_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic [15:0] seed_i,
   output logic [15:0] state_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;
   logic [15:0] seed_eff;

   // NOTE: always_comb drives every variable on every path, so no latch can be inferred.
   always_comb begin
      seed_eff = (seed_i == 16'd0) ? 16'd1 : seed_i;
      lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'd0);
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of block order.
   always_ff @(posedge clk_i) begin
      if (!rst_n) lfsr_q <= seed_eff;
      else        lfsr_q <= lfsr_d;
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/ks_pluck_seq.sv
// Step sequencer driving period, pluck and noise into the Karplus-Strong string voice.
module ks_pluck_seq #(
   parameter int          DATA_WIDTH     = 8,
   parameter int          PRBS_WIDTH     = 2,
   parameter int          MAX_LENGTH     = 32,
   parameter int          STEPS          = 8,
   parameter int          TEMPO_WIDTH    = 16,
   parameter int          PLUCK_HOLD     = 4,
   parameter int          DEFAULT_PERIOD = ks_pkg::DEFAULT_PERIOD,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic                       clk_i,
   input  logic                       rst_n,
   input  logic                       run_i,
   input  logic [TEMPO_WIDTH-1:0]     tempo_i,
   input  logic [$clog2(STEPS):0]     steps_i,
   input  logic                       wr_en_i,
   input  logic [$clog2(STEPS)-1:0]   wr_addr_i,
   input  logic [DATA_WIDTH-1:0]      wr_period_i,
   input  logic                       wr_rest_i,
   input  logic                       manual_pluck_i,
   input  logic [DATA_WIDTH-1:0]      manual_period_i,
   output logic                       pluck_o,
   output logic [DATA_WIDTH-1:0]      period_o,
   output logic [PRBS_WIDTH-1:0]      prbs_data_o,
   output logic [$clog2(STEPS)-1:0]   step_idx_o,
   output logic                       busy_o
);

   import ks_pkg::*;

   localparam int STEP_W  = $clog2(STEPS);
   localparam int STEPS_W = $clog2(STEPS) + 1;
   localparam int CNT_W   = TEMPO_WIDTH + 1;
   localparam int HOLD_W  = (PLUCK_HOLD > 1) ? $clog2(PLUCK_HOLD) : 1;

   logic [2:0]            state_q, state_d;
   logic [STEP_W-1:0]     step_q, step_d;
   logic [STEP_W-1:0]     step_idx_q, step_idx_d;
   logic [DATA_WIDTH-1:0] period_q, period_d;
   logic                  manual_q, manual_d;
   logic                  manual_prev_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic                  pluck_q;
   logic                  busy_q;

   logic [DATA_WIDTH-1:0] tbl_period_q [STEPS];
   logic [STEPS-1:0]      tbl_rest_q;

   logic                  manual_edge;
   logic                  last_step;
   logic                  wr_ok;
   logic [STEPS_W-1:0]    steps_eff;
   logic [CNT_W-1:0]      tempo_ext;
   logic [CNT_W-1:0]      interval;
   logic [DATA_WIDTH-1:0] wr_period_clamped;
   logic [DATA_WIDTH-1:0] manual_period_clamped;
   logic [15:0]           lfsr_state;
   logic                  lfsr_unused;

   ks_lfsr u_lfsr (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .seed_i  (LFSR_SEED),
      .state_o (lfsr_state)
   );

   assign lfsr_unused = ^lfsr_state[15:PRBS_WIDTH];

   always_comb begin
      manual_edge           = manual_pluck_i & ~manual_prev_q;
      wr_ok                 = wr_en_i && (int'(wr_addr_i) < STEPS);
      wr_period_clamped     = DATA_WIDTH'(clamp_period(32'(wr_period_i), 32'(MAX_LENGTH)));
      manual_period_clamped = DATA_WIDTH'(clamp_period(32'(manual_period_i), 32'(MAX_LENGTH)));

      if (steps_i == '0)                   steps_eff = STEPS_W'(1);
      else if (steps_i > STEPS_W'(STEPS))  steps_eff = STEPS_W'(STEPS);
      else                                 steps_eff = steps_i;
      last_step = (STEPS_W'(step_q) + STEPS_W'(1)) >= steps_eff;

      // The interval never undercuts SETTLE plus the full pluck plus one WAIT cycle.
      tempo_ext = CNT_W'(tempo_i) + CNT_W'(1);
      interval  = (tempo_ext > CNT_W'(PLUCK_HOLD + 3)) ? tempo_ext : CNT_W'(PLUCK_HOLD + 3);
   end

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      step_idx_d = step_idx_q;
      period_d   = period_q;
      manual_d   = manual_q;
      hold_d     = hold_q;
      cnt_d      = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

      // Stopping a run never touches period_o, so the string keeps ringing at its pitch.
      if (state_q != ST_IDLE && !manual_q && !run_i) begin
         state_d    = ST_IDLE;
         step_d     = '0;
         step_idx_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run_i) begin
                  state_d  = ST_LOAD;
                  step_d   = '0;
                  manual_d = 1'b0;
               end else if (manual_edge) begin
                  state_d  = ST_LOAD;
                  manual_d = 1'b1;
               end
            end
            ST_LOAD: begin
               period_d   = manual_q ? manual_period_clamped : tbl_period_q[step_q];
               step_idx_d = step_q;
               cnt_d      = interval - CNT_W'(2);
               state_d    = (!manual_q && tbl_rest_q[step_q]) ? ST_WAIT : ST_SETTLE;
            end
            ST_SETTLE: begin
               state_d = ST_PLUCK;
               hold_d  = HOLD_W'(PLUCK_HOLD - 1);
            end
            ST_PLUCK: begin
               if (hold_q == '0) state_d = manual_q ? ST_IDLE : ST_WAIT;
               else              hold_d  = hold_q - HOLD_W'(1);
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_d = ST_LOAD;
                  step_d  = last_step ? '0 : step_q + STEP_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         step_q        <= '0;
         step_idx_q    <= '0;
         period_q      <= DATA_WIDTH'(DEFAULT_PERIOD);
         manual_q      <= 1'b0;
         manual_prev_q <= 1'b0;
         cnt_q         <= '0;
         hold_q        <= '0;
         pluck_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         step_idx_q    <= step_idx_d;
         period_q      <= period_d;
         manual_q      <= manual_d;
         manual_prev_q <= manual_pluck_i;
         cnt_q         <= cnt_d;
         hold_q        <= hold_d;
         pluck_q       <= (state_d == ST_PLUCK);
         busy_q        <= (state_d != ST_IDLE);
      end
   end

   // NOTE: the step table is a handful of flops rather than a RAM macro, so every entry is reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         for (int i = 0; i < STEPS; i++) tbl_period_q[i] <= DATA_WIDTH'(DEFAULT_PERIOD);
         tbl_rest_q <= '0;
      end else if (wr_ok) begin
         tbl_period_q[wr_addr_i] <= wr_period_clamped;
         tbl_rest_q[wr_addr_i]   <= wr_rest_i;
      end
   end

   assign pluck_o     = pluck_q;
   assign period_o    = period_q;
   assign prbs_data_o = lfsr_state[PRBS_WIDTH-1:0];
   assign step_idx_o  = step_idx_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_ks_pluck_seq.sv
// Bench for ks_pluck_seq: directed scenarios plus random stimulus against a time-schedule reference model.
module tb_ks_pluck_seq;

   logic        clk_i = 1'b0;
   logic        rst_n;
   logic        run_i;
   logic [15:0] tempo_i;
   logic [3:0]  steps_i;
   logic        wr_en_i;
   logic [2:0]  wr_addr_i;
   logic [7:0]  wr_period_i;
   logic        wr_rest_i;
   logic        manual_pluck_i;
   logic [7:0]  manual_period_i;
   logic        pluck_o;
   logic [7:0]  period_o;
   logic [1:0]  prbs_data_o;
   logic [2:0]  step_idx_o;
   logic        busy_o;

   ks_pluck_seq dut (
      .clk_i           (clk_i),
      .rst_n           (rst_n),
      .run_i           (run_i),
      .tempo_i         (tempo_i),
      .steps_i         (steps_i),
      .wr_en_i         (wr_en_i),
      .wr_addr_i       (wr_addr_i),
      .wr_period_i     (wr_period_i),
      .wr_rest_i       (wr_rest_i),
      .manual_pluck_i  (manual_pluck_i),
      .manual_period_i (manual_period_i),
      .pluck_o         (pluck_o),
      .period_o        (period_o),
      .prbs_data_o     (prbs_data_o),
      .step_idx_o      (step_idx_o),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: tracks when the last LOAD happened and derives every output from that schedule.
   logic [15:0] m_lfsr;
   logic [7:0]  m_tbl [8];
   bit          m_rest [8];
   bit          m_busy, m_manual, m_plucks, m_man_prev;
   int          m_step, m_idx, m_load, m_T;
   logic [7:0]  m_period;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_clamp(input logic [7:0] p);
      if (p == 8'd0) return 8'd1;
      if (p > 8'd32) return 8'd32;
      return p;
   endfunction

   // Called at the rising edge with the inputs held during the cycle that edge closes.
   task automatic model_tick();
      int seff;
      if (!rst_n) begin
         m_lfsr = 16'hACE1; m_busy = 0; m_manual = 0; m_plucks = 0; m_man_prev = 0;
         m_step = 0; m_idx = 0; m_load = -100; m_T = 7; m_period = 8'd32;
         for (int i = 0; i < 8; i++) begin
            m_tbl[i]  = 8'd32;
            m_rest[i] = 0;
         end
         cyc++;
         return;
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      if (m_busy && !m_manual && !run_i) begin
         m_busy = 0; m_step = 0; m_idx = 0;
      end else begin
         if (m_busy && m_load == cyc) begin
            m_period = m_manual ? ref_clamp(manual_period_i) : m_tbl[m_step];
            m_idx    = m_step;
            m_T      = int'(tempo_i) + 1;
            if (m_T < 7) m_T = 7;
            m_plucks = m_manual || !m_rest[m_step];
         end
         if (!m_busy) begin
            if (run_i) begin
               m_busy = 1; m_manual = 0; m_step = 0; m_load = cyc + 1;
            end else if (manual_pluck_i && !m_man_prev) begin
               m_busy = 1; m_manual = 1; m_load = cyc + 1;
            end
         end else if (m_manual) begin
            if (cyc + 1 == m_load + 6) m_busy = 0;
         end else if (cyc + 1 == m_load + m_T) begin
            seff = int'(steps_i);
            if (seff == 0) seff = 1;
            if (seff > 8)  seff = 8;
            m_step = (m_step + 1 >= seff) ? 0 : m_step + 1;
            m_load = cyc + 1;
         end
      end
      if (wr_en_i && int'(wr_addr_i) < 8) begin
         m_tbl[wr_addr_i]  = ref_clamp(wr_period_i);
         m_rest[wr_addr_i] = wr_rest_i;
      end
      m_man_prev = manual_pluck_i;
      cyc++;
   endtask

   task automatic compare_outputs();
      bit exp_pluck;
      exp_pluck = m_busy && m_plucks && (cyc >= m_load + 2) && (cyc <= m_load + 5);
      check("period_o",    32'(period_o),    32'(m_period));
      check("pluck_o",     32'(pluck_o),     32'(exp_pluck));
      check("busy_o",      32'(busy_o),      32'(m_busy));
      check("step_idx_o",  32'(step_idx_o),  32'(m_idx));
      check("prbs_data_o", 32'(prbs_data_o), 32'(m_lfsr[1:0]));
   endtask

   // Each cycle: model steps on the rising edge, outputs are compared and inputs driven on the falling edge.
   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_i);
         model_tick();
         @(negedge clk_i);
         compare_outputs();
      end
   endtask

   task automatic write_step(input logic [2:0] addr, input logic [7:0] period, input logic rest);
      wr_en_i = 1'b1; wr_addr_i = addr; wr_period_i = period; wr_rest_i = rest;
      run_cycles(1);
      wr_en_i = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; run_i = 1'b0; tempo_i = '0; steps_i = '0;
      wr_en_i = 1'b0; wr_addr_i = '0; wr_period_i = '0; wr_rest_i = 1'b0;
      manual_pluck_i = 1'b0; manual_period_i = '0;

      // Reset and the first LFSR steps
      run_cycles(3);
      check("rst_period", 32'(period_o), 32);
      check("rst_pluck",  32'(pluck_o), 0);
      check("rst_busy",   32'(busy_o), 0);
      check("rst_idx",    32'(step_idx_o), 0);
      check("rst_prbs",   32'(prbs_data_o), 32'h1);
      rst_n = 1'b1;
      run_cycles(1);
      check("prbs_step1", 32'(prbs_data_o), 32'h0);
      run_cycles(1);
      check("prbs_step2", 32'(prbs_data_o), 32'h0);

      // Basic three-step sequence, 100-cycle interval
      write_step(3'd0, 8'd10, 1'b0);
      write_step(3'd1, 8'd20, 1'b0);
      write_step(3'd2, 8'd30, 1'b0);
      steps_i = 4'd3; tempo_i = 16'd99; run_i = 1'b1;
      run_cycles(2);
      check("basic_period_s0", 32'(period_o), 10);
      check("basic_idx_s0",    32'(step_idx_o), 0);
      check("basic_busy",      32'(busy_o), 1);
      run_cycles(1);
      check("basic_pluck_first", 32'(pluck_o), 1);
      run_cycles(3);
      check("basic_pluck_last",  32'(pluck_o), 1);
      run_cycles(1);
      check("basic_pluck_end",   32'(pluck_o), 0);
      run_cycles(94);
      check("basic_period_hold", 32'(period_o), 10);
      run_cycles(1);
      check("basic_period_s1", 32'(period_o), 20);
      check("basic_idx_s1",    32'(step_idx_o), 1);
      run_cycles(100);
      check("basic_period_s2", 32'(period_o), 30);
      check("basic_idx_s2",    32'(step_idx_o), 2);
      run_cycles(100);
      check("basic_period_wrap", 32'(period_o), 10);
      check("basic_idx_wrap",    32'(step_idx_o), 0);
      run_i = 1'b0;
      run_cycles(3);

      // Step 1 as a rest
      write_step(3'd1, 8'd20, 1'b1);
      run_i = 1'b1;
      run_cycles(102);
      check("rest_period", 32'(period_o), 20);
      check("rest_idx",    32'(step_idx_o), 1);
      run_cycles(1);
      check("rest_no_pluck_a", 32'(pluck_o), 0);
      run_cycles(3);
      check("rest_no_pluck_b", 32'(pluck_o), 0);
      run_cycles(96);
      check("rest_next_period", 32'(period_o), 30);
      run_cycles(1);
      check("rest_next_pluck", 32'(pluck_o), 1);
      run_i = 1'b0;
      run_cycles(3);

      // Period clamps, minimum interval, steps_i of 0
      write_step(3'd0, 8'd0, 1'b0);
      write_step(3'd1, 8'd200, 1'b0);
      tempo_i = 16'd2; steps_i = 4'd0; run_i = 1'b1;
      run_cycles(2);
      check("clamp_low", 32'(period_o), 1);
      run_cycles(1);
      check("clamp_pluck_a", 32'(pluck_o), 1);
      run_cycles(5);
      check("clamp_gap_pluck", 32'(pluck_o), 0);
      run_cycles(1);
      check("clamp_single_step", 32'(step_idx_o), 0);
      run_cycles(1);
      check("clamp_pluck_b", 32'(pluck_o), 1);
      run_i = 1'b0;
      run_cycles(3);
      steps_i = 4'd2; run_i = 1'b1;
      run_cycles(9);
      check("clamp_high", 32'(period_o), 32);
      check("clamp_high_idx", 32'(step_idx_o), 1);
      run_i = 1'b0;
      run_cycles(3);

      // Stop in the second PLUCK cycle of step 1, then restart
      run_i = 1'b1;
      run_cycles(11);
      check("stop_pre_pluck",  32'(pluck_o), 1);
      check("stop_pre_period", 32'(period_o), 32);
      run_i = 1'b0;
      run_cycles(1);
      check("stop_pluck_drop", 32'(pluck_o), 0);
      check("stop_busy",       32'(busy_o), 0);
      check("stop_period",     32'(period_o), 32);
      run_cycles(2);
      check("stop_idle",       32'(busy_o), 0);
      run_i = 1'b1;
      run_cycles(2);
      check("restart_period", 32'(period_o), 1);
      check("restart_idx",    32'(step_idx_o), 0);
      run_i = 1'b0;
      run_cycles(3);

      // Manual one-shot with a second edge while busy
      manual_period_i = 8'd17; manual_pluck_i = 1'b1;
      run_cycles(2);
      check("manual_period", 32'(period_o), 17);
      check("manual_busy",   32'(busy_o), 1);
      run_cycles(1);
      check("manual_pluck_first", 32'(pluck_o), 1);
      manual_pluck_i = 1'b0;
      run_cycles(1);
      manual_pluck_i = 1'b1;
      run_cycles(2);
      check("manual_pluck_last", 32'(pluck_o), 1);
      run_cycles(1);
      check("manual_done_pluck", 32'(pluck_o), 0);
      check("manual_done_busy",  32'(busy_o), 0);
      run_cycles(3);
      check("manual_edge_ignored", 32'(busy_o), 0);
      manual_pluck_i = 1'b0;
      run_cycles(2);

      // Random traffic with one mid-run reset
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 149) == 0) run_i = ~run_i;
         if ($urandom_range(0, 9) == 0)   manual_pluck_i = ~manual_pluck_i;
         manual_period_i = 8'($urandom);
         wr_en_i         = ($urandom_range(0, 7) == 0);
         wr_addr_i       = 3'($urandom);
         wr_period_i     = 8'($urandom);
         wr_rest_i       = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 49) == 0) tempo_i = 16'($urandom_range(0, 24));
         if ($urandom_range(0, 99) == 0) steps_i = 4'($urandom_range(0, 15));
         rst_n = !(i >= 2000 && i < 2002);
         run_cycles(1);
      end
      wr_en_i = 1'b0;
      run_cycles(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
